cache_arbiter: RTL
==================

# cache_arbiter

Two-port arbiter sharing one physical-memory port between the instruction cache and the data cache of the pipelined LC-3b core. Each cache's physical-memory side (16-bit address, 128-bit line) connects to the arbiter. The arbiter's downstream port connects to physical memory. The arbiter grants the port to one cache at a time, latches its command, runs the line transfer to completion, and routes the response back. Ties are broken round-robin so neither cache starves.

## Interface
Parameters:
- ADDR_WIDTH, 16, physical address width
- LINE_WIDTH, 128, cache line width

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- icache_pmem_read  in  1  I-cache line-read request (I-cache never writes)
- icache_pmem_address  in  ADDR_WIDTH  I-cache line address
- icache_pmem_rdata  out  LINE_WIDTH  line data to I-cache
- icache_pmem_resp  out  1  I-cache transfer complete
- dcache_pmem_read  in  1  D-cache line-read request
- dcache_pmem_write  in  1  D-cache line-writeback request
- dcache_pmem_address  in  ADDR_WIDTH  D-cache line address
- dcache_pmem_wdata  in  LINE_WIDTH  D-cache writeback data
- dcache_pmem_rdata  out  LINE_WIDTH  line data to D-cache
- dcache_pmem_resp  out  1  D-cache transfer complete
- pmem_read  out  1  physical memory read
- pmem_write  out  1  physical memory write
- pmem_address  out  ADDR_WIDTH  physical memory address
- pmem_wdata  out  LINE_WIDTH  physical memory write data
- pmem_rdata  in  LINE_WIDTH  physical memory read data
- pmem_resp  in  1  physical memory transfer complete

## Operation
- States:
  - IDLE: no grant.
  - SERVE_I: I-cache owns the port.
  - SERVE_D: D-cache owns the port.
- Register `last` records the most recently granted requester. Reset value is D, so the I-cache wins the first tie.
- Request definitions:
  - I request = icache_pmem_read.
  - D request = dcache_pmem_read | dcache_pmem_write.
  - If D asserts both read and write, it is treated as a write.
- Arbitration in IDLE at each edge:
  - Only one requester asserting: grant it.
  - Both asserting: grant the one not equal to `last`.
  - Neither asserting: stay in IDLE.
- On grant, the arbiter latches into output registers:
  - command (read or write)
  - address
  - for D writes, wdata
  - `last` is updated to the granted requester.
- pmem_read, pmem_write, pmem_address and pmem_wdata are driven only from these registers. pmem_read and pmem_write are high for the entire SERVE state; at most one of them is ever high.
- Response routing (combinational):
  - In SERVE_x, x_pmem_resp = pmem_resp.
  - The other requester's resp is 0.
  - In IDLE, both resps are 0, and a pmem_resp arriving in IDLE is ignored.
- pmem_rdata is broadcast to both rdata outputs. It is valid only when qualified by the matching resp.
- Transitions out of a SERVE state, on the edge where pmem_resp=1:
  - If the other requester is asserting, go directly to its SERVE state (no dead cycle).
  - Otherwise go to IDLE.
  - The just-served requester's still-high request in the resp cycle is never re-granted on that edge.
- Requesters must hold request, address and wdata stable until their resp. Changes during SERVE do not affect the latched transfer.
- A request deasserted mid-transfer does not abort it. The arbiter stays in SERVE until pmem_resp.

## Timing
- Reset values: state=IDLE, last=D, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0. Both resp outputs are 0.
- Arbitration latency is 1 cycle. A request sampled at edge T puts pmem_read or pmem_write high from T until the edge at which pmem_resp is sampled.
- Response latency: the requester's resp is asserted in the same cycle as pmem_resp (zero added latency) and lasts exactly as long as pmem_resp in SERVE.
- Back-to-back transfers with the other requester pending: the pmem command stays high continuously across the handover edge, with new address and command registered at that edge.
- Reset mid-transfer (rst=1 at any edge):
  - state goes to IDLE, outputs take their reset values, `last` goes to D.
  - A late pmem_resp after reset is ignored.
  - A requester still asserting after reset is re-arbitrated normally.
- pmem_resp is assumed to be a single cycle per transfer. If it stays high into the next state, it is treated as belonging to whatever is then granted; physical memory must not do this.

## Test plan
- Reset, then I reads 0x1230 alone:
  - pmem_read=1 and pmem_address=0x1230 from the next cycle.
  - Memory responds after 5 cycles with rdata=0xAAAA…: icache_pmem_resp=1 for 1 cycle with that data; dcache_pmem_resp stays 0.
- D writeback of 0x8040 with wdata=0x0123…CDEF: pmem_write=1, pmem_wdata matches, pmem_read=0; resp goes to D only; state returns to IDLE.
- I and D request in the same cycle right after reset:
  - I is granted first (last=D).
  - At I's resp edge, D is granted with no idle cycle, and pmem_address switches to D's address.
- Repeat simultaneous requests 4 times, with each requester re-requesting immediately after its resp: grants alternate I, D, I, D.
- rst=1 two cycles into a D read: next cycle pmem_read=0 and state is IDLE. A pmem_resp pulse one cycle later produces no resp on either cache.
- D changes its address from 0x1000 to 0x2000 mid-transfer: pmem_address stays 0x1000 until resp.

Source files
------------

// File: rtl/cache_arbiter_if.sv
// Memory-side bus shared by the I-cache, the D-cache and physical memory.
// The arbiter uses the master view; caches and memory use the slave view.
interface cache_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
);
    // I-cache side (read only)
    logic                  icache_pmem_read;
    logic [ADDR_WIDTH-1:0] icache_pmem_address;
    logic [LINE_WIDTH-1:0] icache_pmem_rdata;
    logic                  icache_pmem_resp;

    // D-cache side
    logic                  dcache_pmem_read;
    logic                  dcache_pmem_write;
    logic [ADDR_WIDTH-1:0] dcache_pmem_address;
    logic [LINE_WIDTH-1:0] dcache_pmem_wdata;
    logic [LINE_WIDTH-1:0] dcache_pmem_rdata;
    logic                  dcache_pmem_resp;

    // Physical memory side
    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    modport master (
        input  icache_pmem_read, icache_pmem_address,
        output icache_pmem_rdata, icache_pmem_resp,
        input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
        output dcache_pmem_rdata, dcache_pmem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport slave (
        output icache_pmem_read, icache_pmem_address,
        input  icache_pmem_rdata, icache_pmem_resp,
        output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
        input  dcache_pmem_rdata, dcache_pmem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the I-cache
// and the D-cache. The granted command is registered and held until memory
// responds; the response is routed combinationally to the owner.
module cache_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    cache_arbiter_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic                  last_d;      // 1: D-cache was granted most recently
    logic                  grant_i;
    logic                  grant_d;
    logic                  i_req;
    logic                  d_req;

    logic                  read_q;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;

    assign i_req = bus.icache_pmem_read;
    assign d_req = bus.dcache_pmem_read | bus.dcache_pmem_write;

    assign bus.pmem_read    = read_q;
    assign bus.pmem_write   = write_q;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;

    // Line data is broadcast; each cache qualifies it with its own resp.
    assign bus.icache_pmem_rdata = bus.pmem_rdata;
    assign bus.dcache_pmem_rdata = bus.pmem_rdata;

    // State, round-robin pointer and latched memory command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last_d  <= 1'b1;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_next;
            if (grant_i) begin
                last_d  <= 1'b0;
                read_q  <= 1'b1;
                write_q <= 1'b0;
                addr_q  <= bus.icache_pmem_address;
            end else if (grant_d) begin
                last_d  <= 1'b1;
                // Read together with write counts as a writeback.
                read_q  <= ~bus.dcache_pmem_write;
                write_q <= bus.dcache_pmem_write;
                addr_q  <= bus.dcache_pmem_address;
                if (bus.dcache_pmem_write) begin
                    wdata_q <= bus.dcache_pmem_wdata;
                end
            end else if (state_next == IDLE) begin
                read_q  <= 1'b0;
                write_q <= 1'b0;
            end
        end
    end

    // Grant decision: tie goes to the requester not served last; at the end of
    // a transfer only the other requester may be granted on that edge.
    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (i_req && (!d_req || last_d)) begin
                    grant_i = 1'b1;
                end else if (d_req) begin
                    grant_d = 1'b1;
                end
            end
            SERVE_I: begin
                if (bus.pmem_resp) begin
                    if (d_req) begin
                        grant_d = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            SERVE_D: begin
                if (bus.pmem_resp) begin
                    if (i_req) begin
                        grant_i = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (grant_i) begin
            state_next = SERVE_I;
        end else if (grant_d) begin
            state_next = SERVE_D;
        end
    end

    // Route the memory response to the current owner only.
    always_comb begin
        bus.icache_pmem_resp = 1'b0;
        bus.dcache_pmem_resp = 1'b0;
        if (state == SERVE_I) begin
            bus.icache_pmem_resp = bus.pmem_resp;
        end
        if (state == SERVE_D) begin
            bus.dcache_pmem_resp = bus.pmem_resp;
        end
    end
endmodule
